// File: rtl/pipe_pkg.sv
// Shared definitions for the valid/ready pipeline skid register.
// State encoding, occupancy/stat widths and a state-to-occupancy helper.
package pipe_pkg;

  localparam int unsigned ST_W   = 2;
  localparam int unsigned OCC_W  = 2;
  localparam int unsigned STAT_W = 16;

  localparam logic [ST_W-1:0] ST_EMPTY = 2'd0;
  localparam logic [ST_W-1:0] ST_FULL  = 2'd1;
  localparam logic [ST_W-1:0] ST_SKID  = 2'd2;

  // Number of entries held in a given state.
  function automatic logic [OCC_W-1:0] occOf(input logic [ST_W-1:0] st);
    logic [OCC_W-1:0] occ;
    occ = 2'd0;
    case (st)
      ST_FULL: occ = 2'd1;
      ST_SKID: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_en_reg.sv
// W-bit D register with load enable and asynchronous active-low clear.
module pipe_en_reg #(
  parameter int unsigned W = 8
) (
  input  logic         Clk,
  input  logic         Clrn,
  input  logic         En,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q
);

  // Load on enable, clear on reset.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      Q <= '0;
    end else if (En) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid
// buffer. InReady depends only on registered state. Control is zeroed on
// bubbles so an empty or flushed stage presents a NOP downstream.
// Optional feature macro: PIPE_SKID_STATS_EN adds a saturating StallCnt output.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CW = 8,
  parameter int unsigned DW = 128
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic              InValid,
  output logic              InReady,
  input  logic [CW-1:0]     InCtrl,
  input  logic [DW-1:0]     InData,
  input  logic              Flush,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [CW-1:0]     OutCtrl,
  output logic [DW-1:0]     OutData,
  output logic [OCC_W-1:0]  Occ
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [STAT_W-1:0] StallCnt
`endif
);

  logic [ST_W-1:0] state;
  logic [ST_W-1:0] nextState;

  logic            inFire;
  logic            outFire;
  logic            mainCtrlEn;
  logic            mainDataEn;
  logic            skidEn;
  logic            mainFromSkid;
  logic            mainCtrlZero;

  logic [CW-1:0]   skidCtrl;
  logic [DW-1:0]   skidData;
  logic [CW-1:0]   mainCtrlD;
  logic [DW-1:0]   mainDataD;

  assign inFire  = InValid & InReady;
  assign outFire = OutValid & OutReady;

  // Next-state and register-load decode; Flush overrides every transition.
  always_comb begin
    nextState    = state;
    mainCtrlEn   = 1'b0;
    mainDataEn   = 1'b0;
    skidEn       = 1'b0;
    mainFromSkid = 1'b0;
    mainCtrlZero = 1'b0;
    if (Flush) begin
      nextState    = ST_EMPTY;
      mainCtrlEn   = 1'b1;
      mainCtrlZero = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (inFire) begin
            nextState  = ST_FULL;
            mainCtrlEn = 1'b1;
            mainDataEn = 1'b1;
          end
        end
        ST_FULL: begin
          if (inFire && outFire) begin
            mainCtrlEn = 1'b1;
            mainDataEn = 1'b1;
          end else if (inFire) begin
            nextState = ST_SKID;
            skidEn    = 1'b1;
          end else if (outFire) begin
            nextState    = ST_EMPTY;
            mainCtrlEn   = 1'b1;
            mainCtrlZero = 1'b1;
          end
        end
        ST_SKID: begin
          if (outFire) begin
            nextState    = ST_FULL;
            mainCtrlEn   = 1'b1;
            mainDataEn   = 1'b1;
            mainFromSkid = 1'b1;
          end
        end
        default: begin
          nextState    = ST_EMPTY;
          mainCtrlEn   = 1'b1;
          mainCtrlZero = 1'b1;
        end
      endcase
    end
  end

  // Main-register input select: bubble zero, skid drain or upstream entry.
  always_comb begin
    mainCtrlD = InCtrl;
    mainDataD = InData;
    if (mainFromSkid) begin
      mainCtrlD = skidCtrl;
      mainDataD = skidData;
    end
    if (mainCtrlZero) begin
      mainCtrlD = '0;
    end
  end

  // State plus registered status outputs decoded from the next state.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state    <= ST_EMPTY;
      InReady  <= 1'b1;
      OutValid <= 1'b0;
      Occ      <= '0;
    end else begin
      state    <= nextState;
      InReady  <= (nextState != ST_SKID);
      OutValid <= (nextState != ST_EMPTY);
      Occ      <= occOf(nextState);
    end
  end

  pipe_en_reg #(.W(CW)) uMainCtrl (
    .Clk  (Clk),
    .Clrn (Clrn),
    .En   (mainCtrlEn),
    .D    (mainCtrlD),
    .Q    (OutCtrl)
  );

  pipe_en_reg #(.W(DW)) uMainData (
    .Clk  (Clk),
    .Clrn (Clrn),
    .En   (mainDataEn),
    .D    (mainDataD),
    .Q    (OutData)
  );

  pipe_en_reg #(.W(CW)) uSkidCtrl (
    .Clk  (Clk),
    .Clrn (Clrn),
    .En   (skidEn),
    .D    (InCtrl),
    .Q    (skidCtrl)
  );

  pipe_en_reg #(.W(DW)) uSkidData (
    .Clk  (Clk),
    .Clrn (Clrn),
    .En   (skidEn),
    .D    (InData),
    .Q    (skidData)
  );

`ifdef PIPE_SKID_STATS_EN
  // Saturating count of cycles where a valid entry is held back downstream.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      StallCnt <= '0;
    end else if (OutValid && !OutReady && (StallCnt != {STAT_W{1'b1}})) begin
      StallCnt <= StallCnt + STAT_W'(1);
    end
  end
`endif

endmodule
